// File: rtl/sprite_rom_arbiter_if.sv
// Request/response bundle between sprite ROM requesters and the arbiter.
// Requester i owns bit i of the one-hot vectors and req_addr[i*ADDR_W +: ADDR_W].
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite ROM among NUM_REQ requesters.
// A one-hot tag travels alongside each read so the data returns on the right strobe.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic              pri_lock,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [DATA_W-1:0] rom_q,
  sprite_rom_arbiter_if.slave bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   rr_ptr_reg;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [ADDR_W-1:0]  rom_address_reg;
  logic [NUM_REQ-1:0] tag_reg [ROM_LAT];
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0]  rsp_data_reg;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic               grant_any;
  logic               lock_win;
  logic [ADDR_W-1:0]  req_addr_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_addr_arr[gi] = bus.req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // Scan from rr_ptr upward; the lock path bypasses the scan and leaves rr_ptr alone.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    grant_any = 1'b0;
    lock_win  = 1'b0;
    if (!reset) begin
      if (pri_lock && bus.req_valid[0]) begin
        grant[0]  = 1'b1;
        grant_any = 1'b1;
        lock_win  = 1'b1;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          scan_idx = PTR_W'((int'(rr_ptr_reg) + k) % NUM_REQ);
          if (!grant_any && bus.req_valid[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            grant_idx       = scan_idx;
            grant_any       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant_any && !lock_win) begin
      rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rr_ptr_reg      <= '0;
      rom_address_reg <= '0;
      rsp_valid_reg   <= '0;
      rsp_data_reg    <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        tag_reg[k] <= '0;
      end
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      if (grant_any) begin
        rom_address_reg <= req_addr_arr[grant_idx];
      end
      // An empty grant vector enters the pipe as a bubble.
      tag_reg[0] <= grant;
      for (int k = 1; k < ROM_LAT; k++) begin
        tag_reg[k] <= tag_reg[k-1];
      end
      rsp_valid_reg <= tag_reg[ROM_LAT-1];
      if (|tag_reg[ROM_LAT-1]) begin
        rsp_data_reg <= rom_q;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign rom_address   = rom_address_reg;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench: two arbiters (ROM_LAT=1 and ROM_LAT=3) share one stimulus stream,
// each with its own ROM model of matching latency.
module tb_sprite_rom_arbiter;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        pri_lock = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [10:0] addr [4];
  logic [10:0] rom_address_a;
  logic [10:0] rom_address_b;
  logic [3:0]  rom_q_a;
  logic [3:0]  rom_q_b;
  logic [3:0]  rom_p1;
  logic [3:0]  rom_p2;
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 vga_clk = ~vga_clk;

  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4)) bus_a ();
  sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_b.req_valid = req_valid;
  assign bus_a.req_addr  = {addr[3], addr[2], addr[1], addr[0]};
  assign bus_b.req_addr  = {addr[3], addr[2], addr[1], addr[0]};

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4), .ROM_LAT(1)) dut_a (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .pri_lock   (pri_lock),
    .rom_address(rom_address_a),
    .rom_q      (rom_q_a),
    .bus        (bus_a.slave)
  );

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(11), .DATA_W(4), .ROM_LAT(3)) dut_b (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .pri_lock   (pri_lock),
    .rom_address(rom_address_b),
    .rom_q      (rom_q_b),
    .bus        (bus_b.slave)
  );

  // ROM contents: low nibble of 5*a+3 (37->12, 10->5, 20->7, 30->9, 40->11).
  function automatic logic [3:0] rom_f(input logic [10:0] a);
    logic [10:0] t;
    t = a * 11'd5 + 11'd3;
    return t[3:0];
  endfunction

  assign rom_q_a = rom_f(rom_address_a);

  always_ff @(posedge vga_clk) begin
    rom_p1 <= rom_f(rom_address_b);
    rom_p2 <= rom_p1;
  end
  assign rom_q_b = rom_p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic next_cycle();
    @(posedge vga_clk);
    #1;
  endtask

  logic [3:0]  exp_ready4 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [10:0] tbl_addr [4]   = '{11'd10, 11'd20, 11'd30, 11'd40};
  logic [3:0]  tbl_data [4]   = '{4'd5, 4'd7, 4'd9, 4'd11};
  logic [3:0]  skip_ready [3] = '{4'b0001, 4'b0100, 4'b0001};

  initial begin
    for (int i = 0; i < 4; i++) addr[i] = '0;

    // Reset state and ready suppression while reset is high
    next_cycle();
    next_cycle();
    req_valid = 4'b1111;
    #1;
    check("rst_ready", bus_a.req_ready, 4'b0000);
    check("rst_rom_addr", rom_address_a, 11'd0);
    check("rst_rsp_valid", bus_a.rsp_valid, 4'b0000);
    check("rst_rsp_data", bus_a.rsp_data, 4'd0);

    // Single request, address 37
    reset = 1'b0;
    addr[0] = 11'd37;
    req_valid = 4'b0001;
    #1;
    check("single_ready", bus_a.req_ready, 4'b0001);
    next_cycle();
    req_valid = 4'b0000;
    #1;
    check("single_rom_addr", rom_address_a, 11'd37);
    check("single_rsp_early", bus_a.rsp_valid, 4'b0000);
    next_cycle();
    #1;
    check("single_rsp_valid", bus_a.rsp_valid, 4'b0001);
    check("single_rsp_data", bus_a.rsp_data, 4'd12);
    next_cycle();
    #1;
    check("single_rsp_drop", bus_a.rsp_valid, 4'b0000);
    check("single_data_hold", bus_a.rsp_data, 4'd12);

    // Round-robin fairness from reset
    reset = 1'b1;
    req_valid = 4'b0000;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) addr[i] = tbl_addr[i];
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 8) ? 4'b1111 : 4'b0000;
      #1;
      check($sformatf("rr_ready_%0d", i), bus_a.req_ready, (i < 8) ? exp_ready4[i % 4] : 4'b0000);
      if (i >= 1 && i <= 8)
        check($sformatf("rr_rom_addr_%0d", i), rom_address_a, tbl_addr[(i - 1) % 4]);
      if (i >= 2) begin
        check($sformatf("rr_rsp_valid_%0d", i), bus_a.rsp_valid, exp_ready4[(i - 2) % 4]);
        check($sformatf("rr_rsp_data_%0d", i), bus_a.rsp_data, tbl_data[(i - 2) % 4]);
      end else begin
        check($sformatf("rr_rsp_valid_%0d", i), bus_a.rsp_valid, 4'b0000);
      end
      next_cycle();
    end

    // Pointer wrap and skip: grant 2 leaves rr_ptr=3, then 0101 alternates 0,2,0
    addr[0] = 11'd5;
    addr[2] = 11'd200;
    req_valid = 4'b0100;
    #1;
    check("skip_grant2", bus_a.req_ready, 4'b0100);
    next_cycle();
    for (int j = 0; j < 3; j++) begin
      req_valid = 4'b0101;
      #1;
      check($sformatf("skip_ready_%0d", j), bus_a.req_ready, skip_ready[j]);
      next_cycle();
    end
    req_valid = 4'b0000;
    #1;
    check("skip_rom_addr", rom_address_a, 11'd5);
    next_cycle();

    // Priority lock: move rr_ptr to 2 first so the post-lock grant is distinctive
    req_valid = 4'b0010;
    #1;
    check("lock_pre_grant1", bus_a.req_ready, 4'b0010);
    next_cycle();
    pri_lock = 1'b1;
    for (int j = 0; j < 6; j++) begin
      req_valid = 4'b1111;
      #1;
      check($sformatf("lock_ready_%0d", j), bus_a.req_ready, 4'b0001);
      next_cycle();
    end
    pri_lock = 1'b0;
    #1;
    check("lock_release", bus_a.req_ready, 4'b0100);
    next_cycle();
    pri_lock = 1'b1;
    req_valid = 4'b1110;
    #1;
    check("lock_no_req0", bus_a.req_ready, 4'b1000);
    next_cycle();
    pri_lock = 1'b0;
    req_valid = 4'b0000;
    for (int j = 0; j < 4; j++) next_cycle();

    // Reset mid-flight: accept addr 100, reset the next cycle
    addr[0] = 11'd100;
    req_valid = 4'b0001;
    #1;
    check("mid_ready", bus_a.req_ready, 4'b0001);
    next_cycle();
    req_valid = 4'b0000;
    reset = 1'b1;
    #1;
    check("mid_rom_addr", rom_address_a, 11'd100);
    next_cycle();
    reset = 1'b0;
    #1;
    check("mid_rom_addr_rst", rom_address_a, 11'd0);
    check("mid_rsp_a_c2", bus_a.rsp_valid, 4'b0000);
    next_cycle();
    #1;
    check("mid_rsp_a_c3", bus_a.rsp_valid, 4'b0000);
    check("mid_rsp_b_c3", bus_b.rsp_valid, 4'b0000);
    next_cycle();
    #1;
    check("mid_rsp_a_c4", bus_a.rsp_valid, 4'b0000);
    check("mid_rsp_b_c4", bus_b.rsp_valid, 4'b0000);
    check("mid_rom_addr_b", rom_address_b, 11'd0);
    next_cycle();

    // Latency sweep on the ROM_LAT=3 instance
    addr[0] = 11'd37;
    req_valid = 4'b0001;
    #1;
    check("lat3_ready", bus_b.req_ready, 4'b0001);
    next_cycle();
    for (int k = 1; k <= 5; k++) begin
      req_valid = 4'b0000;
      #1;
      check($sformatf("lat3_rsp_valid_c%0d", k), bus_b.rsp_valid, (k == 4) ? 4'b0001 : 4'b0000);
      if (k == 4) check("lat3_rsp_data", bus_b.rsp_data, 4'd12);
      next_cycle();
    end

    // Back-to-back accepts on requester 0 with a changing address
    for (int i = 0; i < 9; i++) begin
      if (i < 4) begin
        req_valid = 4'b0001;
        addr[0] = tbl_addr[i];
      end else begin
        req_valid = 4'b0000;
      end
      #1;
      if (i >= 2 && i <= 5) begin
        check($sformatf("b2b_a_valid_%0d", i), bus_a.rsp_valid, 4'b0001);
        check($sformatf("b2b_a_data_%0d", i), bus_a.rsp_data, tbl_data[i - 2]);
      end else begin
        check($sformatf("b2b_a_valid_%0d", i), bus_a.rsp_valid, 4'b0000);
      end
      if (i >= 4 && i <= 7) begin
        check($sformatf("b2b_b_valid_%0d", i), bus_b.rsp_valid, 4'b0001);
        check($sformatf("b2b_b_data_%0d", i), bus_b.rsp_data, tbl_data[i - 4]);
      end else begin
        check($sformatf("b2b_b_valid_%0d", i), bus_b.rsp_valid, 4'b0000);
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares one sprite ROM (palette-index ROM, fixed read latency) among up to NUM_REQ requesters, e.g. raster pixel fetch, collision probe and sprite preloader.
- Round-robin grant with valid/ready request handshake.
- Returns ROM data to the winning requester on a one-hot response strobe.
- Optional priority lock keeps requester 0 (raster path) unstarved during active video.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 11, ROM address width.
- DATA_W, 4, ROM word width (palette index).
- ROM_LAT, 1, posedge cycles from rom_address change until rom_q may be sampled (1..3).

Ports:
- vga_clk  in  1  system pixel clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester read request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_ready  out  NUM_REQ  one-hot grant, combinational.
- pri_lock  in  1  when high, requester 0 wins whenever it is valid.
- rom_address  out  ADDR_W  registered address to ROM.
- rom_q  in  DATA_W  ROM read data.
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered.
- rsp_data  out  DATA_W  registered ROM data for the strobed requester.

Behaviour:
- Reset (sampled high at posedge): rr_ptr=0, rom_address=0, rsp_valid=0, rsp_data=0, in-flight tag pipeline cleared. req_ready forced to 0 while reset is high. Reset mid-operation drops all in-flight responses; none are emitted after reset deasserts.
- Grant is combinational from req_valid, rr_ptr and pri_lock. At most one req_ready bit is high per cycle. req_ready is 0 for every requester whose req_valid is 0.
- Selection:
  - If pri_lock && req_valid[0]: grant 0, rr_ptr unchanged.
  - Otherwise: grant the first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ. On grant g, rr_ptr <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Accept: a handshake is req_valid[i] && req_ready[i] in cycle C.
- Timing after accept in cycle C:
  - rom_address = req_addr[i] during cycle C+1.
  - Tag pipeline of depth ROM_LAT+1 carries one-hot i.
  - rsp_valid[i]=1 and rsp_data = rom_q (sampled at end of cycle C+ROM_LAT) during cycle C+1+ROM_LAT, for exactly one cycle.
  - With ROM_LAT=1, total latency is 2 cycles.
- Throughput: one accept per cycle, fully pipelined. Back-to-back grants produce back-to-back responses in grant order.
- No response backpressure: requesters must consume rsp_valid when it is strobed.
- Idle cycles (no valid): rom_address holds its last value, rsp pipeline inserts bubbles, rr_ptr unchanged.
- A requester holding req_valid high with a changing req_addr is legal. The address sampled is the one present in the accept cycle.
- rsp_data holds its previous value when rsp_valid==0.
- Requester indices >= NUM_REQ do not exist. No X may propagate from unused packed address bits.

Test Plan:
- Reset then single request: reset 2 cycles, req_valid=0001, req_addr[0]=11'd37 in cycle C → req_ready=0001 in C; rom_address=37 in C+1; rsp_valid=0001 with rsp_data = ROM[37] in C+2; rsp_valid=0000 in C+3.
- Round-robin fairness: req_valid=1111 held 8 cycles from reset, addresses 10/20/30/40 → grants 0,1,2,3,0,1,2,3; responses in the same order, 2 cycles later each, with data ROM[10],ROM[20],ROM[30],ROM[40] repeating.
- Pointer wrap and skip: rr_ptr=3 (after granting 2), req_valid=0101 → grant 0, then 2, then 0; requesters 1 and 3 are never granted.
- Priority lock: pri_lock=1, req_valid=1111 for 6 cycles → requester 0 granted all 6 cycles. Drop pri_lock → next grant follows the pre-lock rr_ptr.
- Reset mid-flight: accept addr 100 in cycle C, assert reset in C+1 → rsp_valid stays 0000 through C+4; rom_address=0 after reset.
- Latency sweep: repeat the first scenario with ROM_LAT=3 and a 3-stage ROM model → rsp_valid exactly in cycle C+4 with correct data; back-to-back accepts produce gapless responses.
